stream_mem_loader: RTL and testbench

- Synthesizable, runtime program loader for the 6502 system on DE10-Lite.
- Accepts a framed byte stream (UART receiver or JTAG bridge) and writes the payload into ROM/RAM at a base address carried in the frame header.
- Holds the CPU in reset while a frame is in progress.
- Replaces simulation-only hex preloading for on-board reprogramming without resynthesis.

---
 rtl/stream_mem_loader.sv | 269 ++++++++++++++++++++++++++
 tb/tb_stream_mem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mem_loader.sv
// ---------------------------------------------------------------------------
// stream_mem_loader
//
// Runtime program loader. It consumes a framed byte stream and writes the
// payload into memory at the base address carried in the frame header. The
// CPU is held in reset while a frame is in progress.
//
// Frame: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, [CSUM]
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : a trailing CSUM byte is expected. The 8-bit sum of
//               ADDR_H..CSUM must be 0, otherwise err_code=1 (done still
//               pulses and the data stays written).
//   undefined : no CSUM byte; err_code never takes value 1.
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   in_valid    input byte valid
//   in_data     input byte
//   in_ready    byte accepted when in_valid & in_ready (low only in FINISH)
//   mem_we      single-cycle memory write strobe
//   mem_addr    write address (ADDR_W bits)
//   mem_wdata   write data
//   cpu_hold    high while loading; drives CPU reset
//   done        one-cycle pulse on frame completion
//   err_code    0 none, 1 checksum, 2 timeout; sticky until next SYNC
//   byte_count  payload bytes written in the current/last frame
// ---------------------------------------------------------------------------
module stream_mem_loader #(
  parameter int unsigned ADDR_W         = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned HOLD_EXTRA     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [15:0]       byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN_H,
    S_LEN_L,
    S_DATA,
    S_CSUM,
    S_FINISH
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t     AFTER_DATA = S_CSUM;
  localparam logic [1:0] ERR_CSUM   = 2'd1;
`else
  localparam state_t     AFTER_DATA = S_FINISH;
`endif
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  localparam int unsigned   TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam int unsigned   HOLD_W   = (HOLD_EXTRA > 0) ? $clog2(HOLD_EXTRA + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_EXTRA);

  state_t              state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         len_q, len_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] hdr_word;

  // High header byte is parked in hi_q; the low byte completes the word.
  assign hdr_word = {hi_q, in_data};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_NONE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      hold_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      hold_q      <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    len_d       = len_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    hold_d      = hold_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d    = S_ADDR_H;
          cpu_hold_d = 1'b1;
          err_d      = ERR_NONE;
          cnt_d      = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      S_ADDR_H: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (accept) begin
          addr_d  = hdr_word[ADDR_W-1:0];
          state_d = S_LEN_H;
        end
      end
      S_LEN_H: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = S_LEN_L;
        end
      end
      S_LEN_L: begin
        if (accept) begin
          len_d   = hdr_word;
          state_d = (hdr_word == 16'd0) ? AFTER_DATA : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = cnt_q + 16'd1;
          len_d       = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d = AFTER_DATA;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          err_d   = ((sum_q + in_data) == 8'h00) ? ERR_NONE : ERR_CSUM;
          state_d = S_FINISH;
        end
      end
`endif
      S_FINISH: begin
        if (hold_q == '0) begin
          state_d    = S_IDLE;
          cpu_hold_d = 1'b0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LOADER_CHECKSUM_EN
    // Running sum over every byte after SYNC, including the CSUM byte itself.
    if (accept && (state_q != S_IDLE) && (state_q != S_FINISH)) begin
      sum_d = sum_q + in_data;
    end
`endif

    // Inactivity watchdog; the abort overrides whatever the case above chose.
    if ((state_q != S_IDLE) && (state_q != S_FINISH)) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_d    = S_IDLE;
        cpu_hold_d = 1'b0;
        err_d      = ERR_TMO;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if ((state_d == S_FINISH) && (state_q != S_FINISH)) begin
      hold_d = HOLD_INIT;
    end
    done_d = (state_d == S_FINISH) && (state_q != S_FINISH);
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready = (state_q != S_FINISH);
    accept   = in_valid & in_ready;
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err_code   = err_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_stream_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_stream_mem_loader
//
// Directed bench for stream_mem_loader. Expected memory writes are pushed to
// a scoreboard queue as data bytes are driven; a negedge monitor pops and
// compares them when mem_we fires. Checksum cases run only when
// LOADER_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module tb_stream_mem_loader;

  localparam int unsigned ADDR_W   = 16;
  localparam logic [7:0]  SYNC     = 8'hA5;
  localparam int unsigned TMO      = 100;
  localparam int unsigned HOLD     = 4;
  localparam logic [15:0] AMASK    = 16'((32'd1 << ADDR_W) - 1);

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic [1:0]        err_code;
  logic [15:0]       byte_count;

  stream_mem_loader #(
    .ADDR_W         (ADDR_W),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO),
    .HOLD_EXTRA     (HOLD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err_code   (err_code),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int first_wr = 0;
  int last_wr = 0;
  int done_cnt = 0;

  logic [23:0] sb[$];
  logic [7:0]  payload[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write monitor / scoreboard consumer
  always @(negedge clk) begin
    logic [23:0] e;
    if (mem_we === 1'b1) begin
      wr_cnt++;
      if (wr_cnt == 1) first_wr = cyc;
      last_wr = cyc;
      if (sb.size() == 0) begin
        check("unexpected_write_sb_size", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[23:8]));
        check("wr_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic send(input logic [7:0] b);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 1000) check("send_ready_timeout", 32'(g), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends header plus every byte in payload; the CSUM byte only when complete.
  task automatic send_frame(input logic [15:0] base, input logic [15:0] len,
                            input bit complete, input bit bad_csum);
    logic [7:0]  sum;
    logic [7:0]  cs;
    logic [15:0] a;
    sum = 8'h00;
    send(SYNC);
    send(base[15:8]); sum = sum + base[15:8];
    send(base[7:0]);  sum = sum + base[7:0];
    send(len[15:8]);  sum = sum + len[15:8];
    send(len[7:0]);   sum = sum + len[7:0];
    for (int i = 0; i < payload.size(); i++) begin
      a = (base + 16'(i)) & AMASK;
      sb.push_back({a, payload[i]});
      send(payload[i]);
      sum = sum + payload[i];
    end
    cs = 8'h00 - sum;
    if (bad_csum) cs = cs + 8'h01;
`ifdef LOADER_CHECKSUM_EN
    if (complete) send(cs);
`else
    if (complete && bad_csum) send(cs);
`endif
  endtask

  task automatic finish_frame(input string tag, input logic [1:0] exp_err,
                              input logic [15:0] exp_cnt, input int d0);
    int g;
    int k;
    g = 0;
    @(negedge clk);
    while (done !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err_code), 32'(exp_err));
    check({tag, "_byte_count"}, 32'(byte_count), 32'(exp_cnt));
    check({tag, "_ready_in_finish"}, 32'(in_ready), 32'd0);
    check({tag, "_hold_at_done"}, 32'(cpu_hold), 32'd1);
    k = 0;
    while (cpu_hold !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_hold_len"}, 32'(k), 32'(HOLD + 1));
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err_code), 32'd0);
    check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
  endtask

  initial begin
    int d0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame, consecutive writes
    payload = '{8'h11, 8'h22, 8'h33};
    wr_cnt = 0;
    d0 = done_cnt;
    send_frame(16'h8000, 16'd3, 1'b1, 1'b0);
    finish_frame("basic", 2'd0, 16'd3, d0);
    check("basic_wr_cnt", 32'(wr_cnt), 32'd3);
    check("basic_consecutive", 32'(last_wr - first_wr), 32'd2);

    // Leading garbage is ignored
    send(8'h00); send(8'hFF); send(8'h5A);
    check("garbage_no_hold", 32'(cpu_hold), 32'd0);
    d0 = done_cnt;
    send_frame(16'h8000, 16'd3, 1'b1, 1'b0);
    finish_frame("garbage", 2'd0, 16'd3, d0);

    // Address wrap-around
    payload = '{8'hAA, 8'hBB};
    d0 = done_cnt;
    send_frame(16'hFFFF, 16'd2, 1'b1, 1'b0);
    finish_frame("wrap", 2'd0, 16'd2, d0);

    // Zero-length frame: no writes
    payload = '{};
    wr_cnt = 0;
    d0 = done_cnt;
    send_frame(16'h4000, 16'd0, 1'b1, 1'b0);
    finish_frame("len0", 2'd0, 16'd0, d0);
    check("len0_no_writes", 32'(wr_cnt), 32'd0);

    // Timeout after 2 of 4 data bytes
    payload = '{8'h01, 8'h02};
    wr_cnt = 0;
    d0 = done_cnt;
    send_frame(16'h1234, 16'd4, 1'b0, 1'b0);
    repeat (TMO - 10) @(negedge clk);
    check("tmo_not_early_hold", 32'(cpu_hold), 32'd1);
    check("tmo_not_early_err", 32'(err_code), 32'd0);
    repeat (20) @(negedge clk);
    check("tmo_err", 32'(err_code), 32'd2);
    check("tmo_hold", 32'(cpu_hold), 32'd0);
    check("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    check("tmo_wr_cnt", 32'(wr_cnt), 32'd2);
    check("tmo_byte_count", 32'(byte_count), 32'd2);
    check("tmo_sb_drained", 32'(sb.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: data written, done pulses, err=1; next SYNC clears it
    payload = '{8'h10, 8'h20, 8'h30};
    d0 = done_cnt;
    send_frame(16'h2000, 16'd3, 1'b1, 1'b1);
    finish_frame("badcs", 2'd1, 16'd3, d0);
    send(SYNC);
    check("badcs_sync_clears_err", 32'(err_code), 32'd0);
    check("badcs_sync_hold", 32'(cpu_hold), 32'd1);
    check("badcs_sync_count", 32'(byte_count), 32'd0);
    send(8'h30); send(8'h00); send(8'h00); send(8'h01);
    sb.push_back({16'h3000, 8'h77});
    send(8'h77);
    send(8'h58);
    d0 = done_cnt - 1;
    finish_frame("after_badcs", 2'd0, 16'd1, d0);
`endif

    // Reset in the middle of DATA with in_valid held high
    payload = '{8'hC1, 8'hC2, 8'hC3};
    wr_cnt = 0;
    send_frame(16'h2000, 16'd8, 1'b0, 1'b0);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5C;
    @(posedge clk); #1;
    check_reset_values("midrst");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_wr_cnt", 32'(wr_cnt), 32'd3);
    check("midrst_sb_drained", 32'(sb.size()), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd0);

    payload = '{8'h11, 8'h22, 8'h33};
    d0 = done_cnt;
    send_frame(16'h8000, 16'd3, 1'b1, 1'b0);
    finish_frame("postrst", 2'd0, 16'd3, d0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
